// File: rtl/i2c_apb_txn_sequencer.sv
// i2c_apb_txn_sequencer
//   APB master that time-shares one I2C master core between NUM_REQ
//   requesters. Each grant runs one single-byte I2C write or read as a fixed
//   string of register accesses, polls the busy bit, and aborts on timeout.
//
// Ports
//   pclk_i, preset_n_i      clock, async active-low reset
//   req_i                   per-requester request, held until done_o
//   req_addr_rw_i           per-requester {7-bit slave addr, rw}
//   req_wdata_i             per-requester write byte
//   cfg_prescaler_i         prescaler value, sampled at grant
//   cfg_done_time_i         cmd[4:0] value, sampled at grant
//   gnt_o                   one-hot grant, held for the whole transaction
//   done_o, err_o           1-cycle completion pulse; err_o=1 on timeout abort
//   rdata_o                 last byte read (held until the next read)
//   psel_o .. pwdata_o      APB master request
//   prdata_i, pready_i      APB response
module i2c_apb_txn_sequencer #(
  parameter int          NUM_REQ        = 2,
  parameter logic [7:0]  ADDR_PRESCALER = 8'h00,
  parameter logic [7:0]  ADDR_CMD       = 8'h01,
  parameter logic [7:0]  ADDR_TRANSMIT  = 8'h02,
  parameter logic [7:0]  ADDR_RECEIVE   = 8'h03,
  parameter logic [7:0]  ADDR_ADDRESS   = 8'h04,
  parameter int          POLL_GAP       = 4,
  parameter int          TIMEOUT_POLLS  = 255
) (
  input  logic                    pclk_i,
  input  logic                    preset_n_i,
  input  logic [NUM_REQ-1:0]      req_i,
  input  logic [NUM_REQ-1:0][7:0] req_addr_rw_i,
  input  logic [NUM_REQ-1:0][7:0] req_wdata_i,
  input  logic [7:0]              cfg_prescaler_i,
  input  logic [4:0]              cfg_done_time_i,
  output logic [NUM_REQ-1:0]      gnt_o,
  output logic [NUM_REQ-1:0]      done_o,
  output logic                    err_o,
  output logic [7:0]              rdata_o,
  output logic                    psel_o,
  output logic                    penable_o,
  output logic                    pwrite_o,
  output logic [7:0]              paddr_o,
  output logic [7:0]              pwdata_o,
  input  logic [7:0]              prdata_i,
  input  logic                    pready_i
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int GW = $clog2(POLL_GAP + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_PRESC, S_WR_ADDR, S_WR_TX, S_WR_CMD,
    S_WAIT, S_POLL, S_RD_RX, S_ABORT, S_DONE
  } state_t;

  // Every APB state walks SETUP -> ACCESS (until pready) -> END. END is the
  // bus-idle cycle after completion and is where the next state is chosen.
  typedef enum logic [1:0] {PH_SETUP, PH_ACCESS, PH_END} phase_t;

  state_t         state_q, state_d;
  phase_t         ph_q, ph_d;
  logic [GW-1:0]  gap_cnt_q;
  logic [7:0]     poll_cnt_q;
  logic [IW-1:0]  ptr_q, pick;
  logic [NUM_REQ-1:0] gnt_q;
  logic [7:0]     addr_rw_q, wdata_q, presc_q, rdata_q;
  logic [4:0]     dtime_q;
  logic           err_q, busy_q;

  logic           is_xfer, xfer_write, xfer_fire, poll_last, grant;
  logic [7:0]     xfer_addr, xfer_wdata;

  // Rotating priority: lowest index above the pointer wins, otherwise the
  // lowest index overall (wrap-around).
  always_comb begin
    pick = ptr_q;
    for (int i = NUM_REQ-1; i >= 0; i--)
      if (req_i[i]) pick = IW'(i);
    for (int i = NUM_REQ-1; i >= 0; i--)
      if (req_i[i] && (IW'(i) > ptr_q)) pick = IW'(i);
  end

  assign grant     = (state_q == S_IDLE) && (|req_i);
  assign xfer_fire = is_xfer && (ph_q == PH_ACCESS) && pready_i;
  assign poll_last = ({1'b0, poll_cnt_q} + 9'd1) >= 9'(TIMEOUT_POLLS);

  always_comb begin
    state_d    = state_q;
    ph_d       = ph_q;
    is_xfer    = 1'b1;
    xfer_addr  = '0;
    xfer_wdata = '0;
    xfer_write = 1'b0;

    case (state_q)
      S_WR_PRESC: begin xfer_addr = ADDR_PRESCALER; xfer_wdata = presc_q;   xfer_write = 1'b1; end
      S_WR_ADDR:  begin xfer_addr = ADDR_ADDRESS;   xfer_wdata = addr_rw_q; xfer_write = 1'b1; end
      S_WR_TX:    begin xfer_addr = ADDR_TRANSMIT;  xfer_wdata = wdata_q;   xfer_write = 1'b1; end
      // {rsvd, enable, reset_n, done_time}
      S_WR_CMD:   begin xfer_addr = ADDR_CMD; xfer_wdata = {3'b011, dtime_q}; xfer_write = 1'b1; end
      S_POLL:     xfer_addr = ADDR_CMD;
      S_RD_RX:    xfer_addr = ADDR_RECEIVE;
      // cmd = 0 drops enable and holds the core in reset
      S_ABORT:    begin xfer_addr = ADDR_CMD; xfer_write = 1'b1; end
      default:    is_xfer = 1'b0;
    endcase

    psel_o    = is_xfer && (ph_q != PH_END);
    penable_o = is_xfer && (ph_q == PH_ACCESS);
    pwrite_o  = psel_o && xfer_write;
    paddr_o   = psel_o   ? xfer_addr  : '0;
    pwdata_o  = pwrite_o ? xfer_wdata : '0;

    case (state_q)
      S_IDLE: if (grant) begin
        state_d = S_WR_PRESC;
        ph_d    = PH_SETUP;
      end
      S_WAIT: if (gap_cnt_q == GW'(POLL_GAP - 1)) begin
        state_d = S_POLL;
        ph_d    = PH_SETUP;
      end
      S_DONE: state_d = S_IDLE;
      default: begin
        case (ph_q)
          PH_SETUP:  ph_d = PH_ACCESS;
          PH_ACCESS: if (pready_i) ph_d = PH_END;
          default: begin
            ph_d = PH_SETUP;
            case (state_q)
              S_WR_PRESC: state_d = S_WR_ADDR;
              S_WR_ADDR:  state_d = addr_rw_q[0] ? S_WR_CMD : S_WR_TX;
              S_WR_TX:    state_d = S_WR_CMD;
              S_WR_CMD:   state_d = S_WAIT;
              S_POLL: begin
                if (!busy_q)        state_d = addr_rw_q[0] ? S_RD_RX : S_DONE;
                else if (poll_last) state_d = S_ABORT;
                else                state_d = S_WAIT;
              end
              default:    state_d = S_DONE;   // RD_RX, ABORT
            endcase
          end
        endcase
      end
    endcase
  end

  always_ff @(posedge pclk_i or negedge preset_n_i) begin
    if (!preset_n_i) begin
      state_q <= S_IDLE;
      ph_q    <= PH_SETUP;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
    end
  end

  always_ff @(posedge pclk_i or negedge preset_n_i) begin
    if (!preset_n_i) begin
      ptr_q      <= IW'(NUM_REQ - 1);
      gnt_q      <= '0;
      addr_rw_q  <= '0;
      wdata_q    <= '0;
      presc_q    <= '0;
      dtime_q    <= '0;
      gap_cnt_q  <= '0;
      poll_cnt_q <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      rdata_q    <= '0;
    end else begin
      if (grant) begin
        ptr_q       <= pick;
        gnt_q       <= '0;
        gnt_q[pick] <= 1'b1;
        addr_rw_q   <= req_addr_rw_i[pick];
        wdata_q     <= req_wdata_i[pick];
        presc_q     <= cfg_prescaler_i;
        dtime_q     <= cfg_done_time_i;
        poll_cnt_q  <= '0;
        err_q       <= 1'b0;
      end
      if (state_q == S_DONE) gnt_q <= '0;
      gap_cnt_q <= (state_q == S_WAIT) ? gap_cnt_q + GW'(1) : '0;
      if (xfer_fire && state_q == S_POLL)  busy_q  <= prdata_i[6];
      if (xfer_fire && state_q == S_RD_RX) rdata_q <= prdata_i;
      if (state_q == S_POLL && ph_q == PH_END && busy_q &&
          poll_cnt_q != 8'(TIMEOUT_POLLS))
        poll_cnt_q <= poll_cnt_q + 8'd1;
      if (state_q == S_ABORT) err_q <= 1'b1;
    end
  end

  assign gnt_o   = gnt_q;
  assign done_o  = (state_q == S_DONE) ? gnt_q : '0;
  assign err_o   = (state_q == S_DONE) && err_q;
  assign rdata_o = rdata_q;

endmodule
